// File: rtl/mem_word_initiator_pkg.sv
// ---------------------------------------------------------------------------
// mem_word_initiator_pkg
// Shared definitions for the word-to-byte memory initiator:
//   WORD_LEN       datapath word width
//   ADDR_LEN       byte address width
//   MEM_CELL_SIZE  memory cell (byte) width
//   state_t        2-bit FSM state encoding (IDLE -> HI -> LO -> RESP)
//   wdog_width()   width of the ack-wait counter for a given timeout
// ---------------------------------------------------------------------------
package mem_word_initiator_pkg;

    localparam int WORD_LEN      = 16;
    localparam int ADDR_LEN      = 16;
    localparam int MEM_CELL_SIZE = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // The counter only has to reach TIMEOUT-1; one extra code keeps the
    // width well-defined for TIMEOUT=1.
    function automatic int wdog_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_ack_watchdog.sv
// ---------------------------------------------------------------------------
// mem_ack_watchdog
// Counts cycles a byte transaction has waited for mem_ack and flags the cycle
// in which the wait budget runs out.
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset
//   clear   in   restart the count (entry into a new byte transaction)
//   tick    in   one more cycle spent waiting (mem_req high, no ack)
//   expire  out  this waiting cycle is the TIMEOUT-th one: abort now
// ---------------------------------------------------------------------------
module mem_ack_watchdog
    import mem_word_initiator_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam int               CNT_W = wdog_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Combinational so the FSM can drop mem_req on the very edge that ends
    // the TIMEOUT-th waiting cycle.
    assign expire = tick && (count_reg == LAST);

endmodule

// File: rtl/mem_word_initiator.sv
// ---------------------------------------------------------------------------
// mem_word_initiator
// Takes one 16-bit load/store from the datapath and performs it as two
// big-endian byte transactions (high byte at addr, low byte at addr+1) on a
// req/ack byte memory port, then returns a one-cycle completion pulse.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cpu_req_valid/ready            request handshake (ready only in IDLE)
//   cpu_req_we/addr/wdata          store flag, high-byte address, store word
//   cpu_resp_valid                 one-cycle completion pulse
//   cpu_resp_rdata                 load word (0 for stores and errors), held
//   cpu_resp_err                   ack timeout, qualified by cpu_resp_valid
//   mem_req/we/addr/wdata          byte transaction to memory (registered)
//   mem_ack/rdata                  byte completion and read byte
// ---------------------------------------------------------------------------
module mem_word_initiator #(
    parameter int WORD_LEN = mem_word_initiator_pkg::WORD_LEN,
    parameter int ADDR_LEN = mem_word_initiator_pkg::ADDR_LEN,
    parameter int CELL_LEN = mem_word_initiator_pkg::MEM_CELL_SIZE,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req_valid,
    output logic                cpu_req_ready,
    input  logic                cpu_req_we,
    input  logic [ADDR_LEN-1:0] cpu_req_addr,
    input  logic [WORD_LEN-1:0] cpu_req_wdata,
    output logic                cpu_resp_valid,
    output logic [WORD_LEN-1:0] cpu_resp_rdata,
    output logic                cpu_resp_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [CELL_LEN-1:0] mem_wdata,
    input  logic                mem_ack,
    input  logic [CELL_LEN-1:0] mem_rdata
);

    import mem_word_initiator_pkg::state_t;
    import mem_word_initiator_pkg::ST_IDLE;
    import mem_word_initiator_pkg::ST_HI;
    import mem_word_initiator_pkg::ST_LO;
    import mem_word_initiator_pkg::ST_RESP;

    state_t              state_reg;
    logic                mem_req_reg;
    logic                mem_we_reg;
    logic [ADDR_LEN-1:0] mem_addr_reg;
    logic [CELL_LEN-1:0] mem_wdata_reg;
    logic [CELL_LEN-1:0] wdata_lo_reg;   // low store byte, parked during HI
    logic [CELL_LEN-1:0] hi_byte_reg;    // high load byte, captured in HI
    logic                resp_valid_reg;
    logic                resp_err_reg;
    logic [WORD_LEN-1:0] resp_rdata_reg;

    logic accept;
    logic wd_clear;
    logic wd_tick;
    logic wd_expire;

    assign accept = cpu_req_valid && (state_reg == ST_IDLE);

    // Restart the wait budget whenever a byte transaction begins: on accept
    // (entering HI) and on the high-byte ack (entering LO).
    assign wd_clear = accept || ((state_reg == ST_HI) && mem_ack);
    // mem_req is only ever high in HI/LO, so it alone qualifies a wait cycle;
    // acks arriving while mem_req is low never reach the FSM either.
    assign wd_tick  = mem_req_reg && !mem_ack;

    mem_ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .tick   (wd_tick),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            wdata_lo_reg   <= '0;
            hi_byte_reg    <= '0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg     <= ST_HI;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= cpu_req_we;
                        mem_addr_reg  <= cpu_req_addr;
                        mem_wdata_reg <= cpu_req_wdata[WORD_LEN-1:CELL_LEN];
                        wdata_lo_reg  <= cpu_req_wdata[CELL_LEN-1:0];
                    end
                end
                ST_HI: begin
                    if (mem_ack) begin
                        // Move straight to the low byte; mem_req stays high so
                        // there is no idle cycle between the two bytes.
                        state_reg     <= ST_LO;
                        hi_byte_reg   <= mem_rdata;
                        mem_addr_reg  <= mem_addr_reg + ADDR_LEN'(1);
                        mem_wdata_reg <= wdata_lo_reg;
                    end else if (wd_expire) begin
                        state_reg      <= ST_RESP;
                        mem_req_reg    <= 1'b0;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= 1'b1;
                        resp_rdata_reg <= '0;
                    end
                end
                ST_LO: begin
                    if (mem_ack) begin
                        state_reg      <= ST_RESP;
                        mem_req_reg    <= 1'b0;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= mem_we_reg ? '0 : {hi_byte_reg, mem_rdata};
                    end else if (wd_expire) begin
                        // A store keeps its already-written high byte.
                        state_reg      <= ST_RESP;
                        mem_req_reg    <= 1'b0;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= 1'b1;
                        resp_rdata_reg <= '0;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_req_ready  = (state_reg == ST_IDLE);
    assign cpu_resp_valid = resp_valid_reg;
    assign cpu_resp_rdata = resp_rdata_reg;
    assign cpu_resp_err   = resp_err_reg;
    assign mem_req        = mem_req_reg;
    assign mem_we         = mem_we_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_wdata      = mem_wdata_reg;

endmodule
